// File: rtl/aes_block_packer.sv
// aes_block_packer
// Collects a byte-wide Avalon-ST message stream into AES-sized blocks.
// Each block goes out on a block-wide Avalon-ST interface with sop/eop/empty.
// Packet framing on the byte side is policed. A violation produces a
// one-cycle err_frame pulse.
module aes_block_packer #(
  parameter  int BLOCK_BYTES = 16,
  localparam int EMPTY_W     = $clog2(BLOCK_BYTES),
  localparam int DATA_W      = 8 * BLOCK_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_rdy,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  output logic               out_valid,
  input  logic               out_rdy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               err_frame
);

  localparam logic [EMPTY_W-1:0] LAST_POS = EMPTY_W'(BLOCK_BYTES - 1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;        // bytes of the block being built
  logic [EMPTY_W-1:0]  r_cnt;        // next free byte slot in r_acc
  logic                r_first;      // block being built is the first of its packet
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [EMPTY_W-1:0]  r_out_empty;
  logic                r_err;

  logic                w_accept;
  logic                w_drop;
  logic                w_store;
  logic                w_complete;
  logic [EMPTY_W-1:0]  w_pos;
  logic                w_first;
  logic [DATA_W-1:0]  w_block;

  // A byte can enter whenever the output register is empty or being drained.
  // The accumulator is therefore never written while a block is stalled.
  assign in_rdy    = ~r_out_valid | out_rdy;
  assign w_accept  = in_valid & in_rdy;
  // A byte that does not open a packet while none is open is thrown away.
  assign w_drop    = w_accept & (r_state == IDLE) & ~in_sop;
  assign w_store   = w_accept & ~w_drop;
  // A sop byte always lands in slot 0, abandoning any partial block.
  assign w_pos     = in_sop ? '0 : r_cnt;
  assign w_first   = in_sop | r_first;
  assign w_complete = w_store & (in_eop | (w_pos == LAST_POS));

  // Build the accumulator image that includes the incoming byte.
  always_comb begin
    // NOTE: every combinational output gets a default first.
    // Without it, a path that skips the assignment infers a latch.
    w_block = in_sop ? '0 : r_acc;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (EMPTY_W'(k) == w_pos) begin
        w_block[DATA_W-1-8*k -: 8] = in_data;
      end
    end
  end

  // Packet FSM, accumulator, and registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together at the edge, independent of statement order.
    if (!rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_drop | (w_accept & in_sop & (r_state == IN_PKT));

      // The encryptor took the beat. Another load below may replace it in the same edge.
      if (r_out_valid && out_rdy) begin
        r_out_valid <= 1'b0;
      end

      if (w_store) begin
        if (w_complete) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_block;
          r_out_sop   <= w_first;
          r_out_eop   <= in_eop;
          r_out_empty <= in_eop ? (LAST_POS - w_pos) : '0;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_first     <= 1'b0;
          r_state     <= in_eop ? IDLE : IN_PKT;
        end else begin
          r_acc       <= w_block;
          r_cnt       <= w_pos + EMPTY_W'(1);
          r_first     <= w_first;
          r_state     <= IN_PKT;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign out_empty = r_out_empty;
  assign err_frame = r_err;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer.
// The reference model keeps each open packet as a byte queue and cuts it into blocks.
// The driver pushes each expected block onto a queue.
// A separate monitor pops and compares every block the DUT hands over.
module tb_aes_block_packer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_rdy;
  logic [7:0]   in_data;
  logic         in_sop;
  logic         in_eop;
  logic         out_valid;
  logic         out_rdy;
  logic [127:0] out_data;
  logic         out_sop;
  logic         out_eop;
  logic [3:0]   out_empty;
  logic         err_frame;

  aes_block_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
  } blk_t;

  blk_t     exp_q[$];
  int       n_vec = 0;
  int       n_err = 0;

  // Reference model state.
  bit       m_open;
  bit       m_first;
  bit [7:0] m_part[$];
  bit       exp_err;     // err_frame expected after the coming edge
  bit       exp_vld;     // a block load is expected at the coming edge

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_open  = 0;
    m_first = 0;
    m_part.delete();
    exp_q.delete();
    exp_err = 0;
    exp_vld = 0;
  endtask

  // Apply the framing and packing rules to one accepted byte.
  task automatic model_byte(input bit [7:0] d, input bit s, input bit e);
    blk_t b;
    if (!m_open && !s) begin
      exp_err = 1;
      return;
    end
    if (s) begin
      if (m_open) exp_err = 1;
      m_part.delete();
      m_first = 1;
      m_open  = 1;
    end
    m_part.push_back(d);
    if (m_part.size() == 16 || e) begin
      b.data = '0;
      for (int i = 0; i < m_part.size(); i++) b.data[127-8*i -: 8] = m_part[i];
      b.sop   = m_first;
      b.eop   = e;
      b.empty = e ? 4'(16 - m_part.size()) : 4'd0;
      exp_q.push_back(b);
      exp_vld = 1;
      m_part.delete();
      m_first = 0;
      if (e) m_open = 0;
    end
  endtask

  // One clock cycle of stimulus. Inputs change at the negedge.
  // Checks run 1 time unit later, once the outputs from the previous edge have settled.
  task automatic cycle(input bit v, input bit [7:0] d, input bit s, input bit e,
                       input bit r, output bit acc);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    out_rdy  = r;
    #1;
    check("err_frame", {127'd0, err_frame}, {127'd0, exp_err});
    if (exp_vld) check("latency", {127'd0, out_valid}, 128'd1);
    check("in_rdy", {127'd0, in_rdy}, {127'd0, (~out_valid | out_rdy)});
    acc     = v & in_rdy;
    exp_err = 0;
    exp_vld = 0;
    if (acc) model_byte(d, s, e);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, r, acc);
  endtask

  // Hold a byte on the bus until the packer takes it.
  task automatic send_byte(input bit [7:0] d, input bit s, input bit e,
                           input bit r, input bit rand_rdy);
    bit acc;
    for (int t = 0; t < 50; t++) begin
      cycle(1, d, s, e, rand_rdy ? ($urandom_range(0, 3) != 0) : r, acc);
      if (acc) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: byte %h not accepted within 50 cycles", d);
  endtask

  task automatic send_pkt(input bit [7:0] base, input int len, input bit r, input bit rand_rdy);
    for (int i = 0; i < len; i++)
      send_byte(8'(base + i), i == 0, i == len - 1, r, rand_rdy);
  endtask

  // Assert reset away from the edges. Check the outputs clear at once, then release.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 0;
    in_valid = 0;
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_rdy", {127'd0, in_rdy}, 128'd1);
    check("rst_err", {127'd0, err_frame}, 128'd0);
    model_reset();
    @(negedge clk);
    #3;
    rst = 1;
  endtask

  // Monitor: compares each transferred block and checks stability while stalled.
  initial begin
    blk_t e;
    blk_t held;
    bit   held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        held_v = 0;
      end else if (out_valid) begin
        if (held_v) begin
          check("stall_data", out_data, held.data);
          check("stall_flags", {122'd0, out_sop, out_eop, out_empty},
                {122'd0, held.sop, held.eop, held.empty});
        end
        if (out_rdy) begin
          held_v = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_block: got %h with no block expected", out_data);
          end else begin
            e = exp_q.pop_front();
            check("blk_data", out_data, e.data);
            check("blk_flags", {122'd0, out_sop, out_eop, out_empty},
                  {122'd0, e.sop, e.eop, e.empty});
          end
        end else begin
          held_v     = 1;
          held.data  = out_data;
          held.sop   = out_sop;
          held.eop   = out_eop;
          held.empty = out_empty;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst      = 0;
    in_valid = 0;
    in_data  = 0;
    in_sop   = 0;
    in_eop   = 0;
    out_rdy  = 0;
    model_reset();
    #12;
    check("reset_outputs", {out_data[7:0], 113'd0, out_valid, out_sop, out_eop, out_empty, err_frame},
          128'd0);
    check("reset_data", out_data, 128'd0);
    check("reset_in_rdy", {127'd0, in_rdy}, 128'd1);
    @(negedge clk);
    #3;
    rst = 1;

    // Full 16-byte packet.
    send_pkt(8'h00, 16, 1, 0);
    idle(2, 1);
    // 20-byte packet: one full block, then a 4-byte tail with empty=12.
    send_pkt(8'h10, 20, 1, 0);
    idle(2, 1);
    // Single-byte packet.
    send_byte(8'hAB, 1, 1, 1, 0);
    idle(2, 1);

    // 32-byte packet with a 5-cycle stall after the first block.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), i == 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'h50, 0, 0, 0, acc);
      check("stall_in_rdy", {127'd0, in_rdy}, 128'd0);
    end
    for (int i = 16; i < 32; i++) send_byte(8'(8'h40 + i), 0, i == 31, 1, 0);
    idle(3, 1);

    // Framing: a stray byte in IDLE, then a restart after 7 open bytes.
    send_byte(8'h55, 0, 0, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h60 + i), i == 0, 0, 1, 0);
    send_pkt(8'hC0, 16, 1, 0);
    idle(2, 1);

    // Reset after 9 open bytes.
    for (int i = 0; i < 9; i++) send_byte(8'(8'h70 + i), i == 0, 0, 1, 0);
    do_reset();
    send_pkt(8'h80, 5, 1, 0);
    idle(2, 1);
    // Reset while a loaded block waits on a stalled output.
    send_pkt(8'h90, 3, 1, 0);
    cycle(0, 8'h00, 0, 0, 0, acc);
    cycle(0, 8'h00, 0, 0, 0, acc);
    do_reset();
    send_pkt(8'hA0, 18, 1, 0);
    idle(2, 1);

    // Random packets with random backpressure, idle gaps and framing faults.
    for (int p = 0; p < 80; p++) begin
      int len;
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 0, $urandom_range(0, 1) == 1, 0, 1);
      for (int i = 0; i < len; i++) begin
        bit s;
        s = (i == 0) || ($urandom_range(0, 59) == 0);
        send_byte(8'($urandom), s, i == len - 1, 0, 1);
        if ($urandom_range(0, 7) == 0) idle(1, $urandom_range(0, 1) == 1);
      end
    end

    // Drain what is still expected.
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1, 1);
    idle(2, 1);
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
